instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word-aligned PC, one-cycle ROM fetch, and a 2-entry
// {instr, pc} buffer feeding decode. Redirects flush the buffer and reload the PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misaligned_err
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;
  logic        err_q, err_d;
  logic        pop, push;

  // Handshake decode; a redirect suppresses both fetch and pop. rom_en is also
  // gated by rst_n so it stays low for the whole reset interval.
  always_comb begin
    pop    = (count_q != 2'd0) && id_ready && !redirect_valid;
    push   = rst_n && !redirect_valid && ((count_q != 2'd2) || pop);
    rom_en = push;
  end

  // Outputs read straight from the head entry; zero when the buffer is empty.
  always_comb begin
    rom_addr       = pc_q;
    id_valid       = (count_q != 2'd0);
    id_instr       = id_valid ? head_instr_q : 32'h0;
    id_pc          = id_valid ? head_pc_q : 32'h0;
    misaligned_err = err_q;
  end

  // Next-state: redirect wins over push/pop/stall; otherwise shift-style FIFO.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    err_d        = err_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = rom_instr;
            head_pc_d    = pc_q;
          end else begin
            tail_instr_d = rom_instr;
            tail_pc_d    = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_instr_d = tail_instr_q;
          head_pc_d    = tail_pc_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_instr_d = rom_instr;
            head_pc_d    = pc_q;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = rom_instr;
            tail_pc_d    = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= ResetPcAligned;
      count_q      <= 2'd0;
      head_instr_q <= 32'h0;
      head_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      err_q        <= err_d;
    end
  end

endmodule
